fetch_pc: RTL

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the instruction memory: it holds the program counter, drives `pc` into the IM, and computes the next PC from sequential, branch, jump and register-jump redirects resolved in ID. It captures the IM's combinational `instr` output into the IF/ID pipeline register, with stall, flush and address-error halt handling.

---
 rtl/fetch_pc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_pc.sv
// Instruction-fetch stage: program counter, next-PC selection for the branch-delay-slot
// pipeline, IF/ID register capture, and sticky fetch-address-error halt.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] id_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  input  logic [31:0] instr_f,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic        addr_err
);

  localparam int unsigned PC_W      = 32;
  localparam logic [32:0] WIN_BYTES = 33'(4 * IM_WORDS);

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]   if_id_pc_q, if_id_pc_d;
  logic [PC_W-1:0]   if_id_pc8_q, if_id_pc8_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic              addr_err_q, addr_err_d;

  logic [PC_W-1:0]   seq_pc_c;
  logic [PC_W-1:0]   branch_pc_c;
  logic [PC_W-1:0]   jump_pc_c;
  logic [PC_W-1:0]   next_pc_c;
  logic [PC_W-1:0]   pc_offset_c;
  logic              pc_bad_c;

  // Redirect targets are relative to the instruction in ID (delay-slot semantics).
  always_comb begin
    seq_pc_c    = pc_q + 32'd4;
    branch_pc_c = id_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    jump_pc_c   = {id_pc[31:28], instr_index, 2'b00};
    next_pc_c   = seq_pc_c;
    unique case (npc_sel)
      NPC_SEQ:    next_pc_c = seq_pc_c;
      NPC_BRANCH: next_pc_c = branch_taken ? branch_pc_c : seq_pc_c;
      NPC_JUMP:   next_pc_c = jump_pc_c;
      NPC_JR:     next_pc_c = rs_val;
      default:    next_pc_c = seq_pc_c;
    endcase
  end

  // Window check done in 33 bits so a window ending at 2^32 cannot wrap.
  always_comb begin
    pc_offset_c = pc_q - RESET_PC;
    pc_bad_c    = (pc_q[1:0] != 2'b00)
               || (pc_q < RESET_PC)
               || ({1'b0, pc_offset_c} >= WIN_BYTES);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc8_d   = if_id_pc8_q;
    if_id_valid_d = if_id_valid_q;
    addr_err_d    = addr_err_q;

    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (pc_bad_c) begin
            state_d       = ST_HALT;
            addr_err_d    = 1'b1;
            if_id_instr_d = 32'd0;
            if_id_pc_d    = 32'd0;
            if_id_pc8_d   = 32'd8;
            if_id_valid_d = 1'b0;
          end else begin
            pc_d = next_pc_c;
            if (flush) begin
              if_id_instr_d = 32'd0;
              if_id_pc_d    = 32'd0;
              if_id_pc8_d   = 32'd8;
              if_id_valid_d = 1'b0;
            end else begin
              if_id_instr_d = instr_f;
              if_id_pc_d    = pc_q;
              if_id_pc8_d   = pc_q + 32'd8;
              if_id_valid_d = 1'b1;
            end
          end
        end
      end
      ST_HALT: begin
        // Frozen until reset; keep feeding bubbles downstream.
        if_id_instr_d = 32'd0;
        if_id_pc_d    = 32'd0;
        if_id_pc8_d   = 32'd8;
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_id_instr_q <= 32'd0;
      if_id_pc_q    <= 32'd0;
      if_id_pc8_q   <= 32'd8;
      if_id_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc8_q   <= if_id_pc8_d;
      if_id_valid_q <= if_id_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc8   = if_id_pc8_q;
  assign if_id_valid = if_id_valid_q;
  assign addr_err    = addr_err_q;

endmodule
